// File: rtl/rc_pkg.sv
// Shared definitions for both ends of the reconfiguration-controller request handshake.
package rc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2,
    GAP   = 2'd3
  } rc_init_state_t;

  localparam logic RC_REQ_ASSERT = 1'b0;
  localparam logic RC_ACK_ASSERT = 1'b0;

  // One counter serves both the timeout and the gap, so it must hold the larger terminal value.
  function automatic int rc_cnt_width(input int timeout, input int min_gap);
    int hi;
    hi = (timeout > min_gap) ? timeout : min_gap;
    return $clog2(hi + 1);
  endfunction

endpackage

// File: rtl/rc_req_initiator_if.sv
// Sequencer/loader/responder-facing signals of the RC request initiator.
interface rc_req_initiator_if;

  logic reconf_req;
  logic reconf_done;
  logic rc_ackn;
  logic rc_reqn;
  logic reconf_grant;
  logic busy;
  logic timeout_err;

  modport master (
    input  reconf_req, reconf_done, rc_ackn,
    output rc_reqn, reconf_grant, busy, timeout_err
  );

  modport slave (
    output reconf_req, reconf_done, rc_ackn,
    input  rc_reqn, reconf_grant, busy, timeout_err
  );

endinterface

// File: rtl/rc_cycle_counter.sv
// Clearable, enableable up-counter with a terminal-count compare against a selectable limit.
module rc_cycle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_terminal = (count_q == terminal);

endmodule

// File: rtl/rc_req_initiator.sv
// Initiator FSM of the RC request/acknowledge handshake: request, grant, inter-request gap,
// with a timeout that abandons a request the responder never acknowledges.
module rc_req_initiator
  import rc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int MIN_GAP = 2
) (
  input logic                clk,
  input logic                rstn,
  rc_req_initiator_if.master bus
);

  localparam int              CNT_W        = rc_cnt_width(TIMEOUT, MIN_GAP);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(MIN_GAP - 1);

  rc_init_state_t   state_d, state_q;
  logic             pending_d, pending_q;
  logic             rc_reqn_d, rc_reqn_q;
  logic             reconf_grant_d, reconf_grant_q;
  logic             timeout_err_d, timeout_err_q;
  logic             cnt_clear, cnt_enable, cnt_at_terminal;
  logic [CNT_W-1:0] cnt_terminal;

  assign cnt_terminal = (state_q == REQ) ? TIMEOUT_LAST : GAP_LAST;

  rc_cycle_counter #(.WIDTH(CNT_W)) u_counter (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (cnt_clear),
    .enable      (cnt_enable),
    .terminal    (cnt_terminal),
    .at_terminal (cnt_at_terminal)
  );

  // A request arriving on the very edge that consumes the pending flag is merged into that one.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | bus.reconf_req;
    cnt_clear     = 1'b0;
    cnt_enable    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q | bus.reconf_req) begin
          state_d   = REQ;
          cnt_clear = 1'b1;
        end
      end
      REQ: begin
        cnt_enable = 1'b1;
        if (bus.rc_ackn == RC_ACK_ASSERT) begin
          state_d   = GRANT;
          pending_d = 1'b0;
        end else if (cnt_at_terminal) begin
          state_d       = GAP;
          pending_d     = 1'b0;
          cnt_clear     = 1'b1;
          timeout_err_d = 1'b1;
        end
      end
      GRANT: begin
        if (bus.reconf_done) begin
          state_d   = GAP;
          cnt_clear = 1'b1;
        end
      end
      GAP: begin
        cnt_enable = 1'b1;
        if (cnt_at_terminal) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so rc_reqn rises on the cycle after the ack.
    rc_reqn_d      = (state_d == REQ) ? RC_REQ_ASSERT : ~RC_REQ_ASSERT;
    reconf_grant_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      pending_q      <= 1'b0;
      rc_reqn_q      <= ~RC_REQ_ASSERT;
      reconf_grant_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      rc_reqn_q      <= rc_reqn_d;
      reconf_grant_q <= reconf_grant_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.rc_reqn      = rc_reqn_q;
  assign bus.reconf_grant = reconf_grant_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
